nibble_unloader: RTL and testbench

- Read-out counterpart of the switch-entry nibble shifter.
- Parallel-loads a 16-bit word, then shifts it out one hex nibble per debounced push-button press, most-significant nibble first.
- The popped nibble drives LEDs or a segdriver digit. The remaining word drives the four-digit HEX display, so the operator watches it drain.
- Sits between a word source (CPU bridge or switch register) and the board's buttons and displays.

---
 rtl/nibble_unloader.sv | 98 +++++++++
 tb/tb_nibble_unloader.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/nibble_unloader.sv
// nibble_unloader: parallel-loads a word and hands it out one hex nibble per
// debounced button press, most-significant nibble first. The remaining word
// stays visible on WORD_OUT so the operator can watch it drain.
module nibble_unloader #(
   parameter int NIBBLES   = 4,
   parameter int DB_CYCLES = 500000,
   parameter int DB_W      = 19
) (
   input  logic                   CLOCK_50,
   input  logic                   RESET_N,
   input  logic                   BTN_N,
   input  logic                   LOAD,
   input  logic [4*NIBBLES-1:0]   DATA_IN,
   output logic [3:0]             NIB_OUT,
   output logic                   NIB_VALID,
   output logic [4*NIBBLES-1:0]   WORD_OUT,
   output logic [2:0]             REMAIN,
   output logic                   EMPTY,
   output logic                   UNDERRUN
);

   localparam int              WORD_W = 4 * NIBBLES;
   localparam logic [DB_W-1:0] DB_MAX = DB_W'(DB_CYCLES - 1);
   localparam logic [2:0]      FULL   = 3'(NIBBLES);

   logic              s1;
   logic              s2;
   logic              db_state;
   logic [DB_W-1:0]   db_cnt;
   logic              press;

   logic [WORD_W-1:0] word;
   logic [2:0]        remain;
   logic [3:0]        nib_out;
   logic              nib_valid;
   logic              underrun;

   // Synchronize the raw button, debounce it, and emit a one-cycle press pulse
   // in the same edge that commits the debounced 1->0 transition.
   always_ff @(posedge CLOCK_50) begin
      if (!RESET_N) begin
         s1       <= 1'b1;
         s2       <= 1'b1;
         db_state <= 1'b1;
         db_cnt   <= '0;
         press    <= 1'b0;
      end else begin
         s1    <= BTN_N;
         s2    <= s1;
         press <= 1'b0;
         if (s2 == db_state) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_MAX) begin
            db_state <= s2;
            db_cnt   <= '0;
            // db_state differs from s2 here, so db_state==1 means a falling edge
            press    <= db_state;
         end else begin
            db_cnt <= db_cnt + 1'b1;
         end
      end
   end

   // Word register and pop logic; LOAD takes priority over a coincident press.
   always_ff @(posedge CLOCK_50) begin
      if (!RESET_N) begin
         word      <= '0;
         remain    <= 3'd0;
         nib_out   <= 4'h0;
         nib_valid <= 1'b0;
         underrun  <= 1'b0;
      end else begin
         nib_valid <= 1'b0;
         underrun  <= 1'b0;
         if (LOAD) begin
            word   <= DATA_IN;
            remain <= FULL;
         end else if (press) begin
            if (remain != 3'd0) begin
               nib_out   <= word[WORD_W-1 -: 4];
               word      <= {word[WORD_W-5:0], 4'h0};
               remain    <= remain - 3'd1;
               nib_valid <= 1'b1;
            end else begin
               underrun  <= 1'b1;
            end
         end
      end
   end

   assign NIB_OUT   = nib_out;
   assign NIB_VALID = nib_valid;
   assign WORD_OUT  = word;
   assign REMAIN    = remain;
   assign EMPTY     = (remain == 3'd0);
   assign UNDERRUN  = underrun;

endmodule

// File: tb/tb_nibble_unloader.sv
// Directed bench for nibble_unloader with a short debounce window.
module tb_nibble_unloader;

   logic        CLOCK_50 = 1'b0;
   logic        RESET_N  = 1'b0;
   logic        BTN_N    = 1'b1;
   logic        LOAD     = 1'b0;
   logic [15:0] DATA_IN  = 16'h0000;
   logic [3:0]  NIB_OUT;
   logic        NIB_VALID;
   logic [15:0] WORD_OUT;
   logic [2:0]  REMAIN;
   logic        EMPTY;
   logic        UNDERRUN;

   int n_cmp = 0;
   int n_err = 0;
   int nv    = 0;
   int ur    = 0;
   int nv0;
   int ur0;

   logic [3:0]  exp_nib  [4] = '{4'hA, 4'h5, 4'hC, 4'h3};
   logic [15:0] exp_word [4] = '{16'h5C30, 16'hC300, 16'h3000, 16'h0000};

   nibble_unloader #(.NIBBLES(4), .DB_CYCLES(4), .DB_W(3)) dut (
      .CLOCK_50  (CLOCK_50),
      .RESET_N   (RESET_N),
      .BTN_N     (BTN_N),
      .LOAD      (LOAD),
      .DATA_IN   (DATA_IN),
      .NIB_OUT   (NIB_OUT),
      .NIB_VALID (NIB_VALID),
      .WORD_OUT  (WORD_OUT),
      .REMAIN    (REMAIN),
      .EMPTY     (EMPTY),
      .UNDERRUN  (UNDERRUN)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to the next falling edge and tally output pulses.
   task automatic cyc();
      @(negedge CLOCK_50);
      if (NIB_VALID) nv++;
      if (UNDERRUN) ur++;
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic clean_press();
      BTN_N = 1'b0;
      cycles(10);
      BTN_N = 1'b1;
      cycles(10);
   endtask

   task automatic load_word(input logic [15:0] d);
      LOAD    = 1'b1;
      DATA_IN = d;
      cyc();
      LOAD    = 1'b0;
   endtask

   task automatic chk_reset_state(input string pfx);
      chk({pfx, "_word"},   32'(WORD_OUT),  32'h0);
      chk({pfx, "_remain"}, 32'(REMAIN),    32'h0);
      chk({pfx, "_empty"},  32'(EMPTY),     32'h1);
      chk({pfx, "_nib"},    32'(NIB_OUT),   32'h0);
      chk({pfx, "_valid"},  32'(NIB_VALID), 32'h0);
      chk({pfx, "_under"},  32'(UNDERRUN),  32'h0);
   endtask

   initial begin
      // 1. reset, load A5C3, four clean presses
      RESET_N = 1'b0;
      cycles(3);
      chk_reset_state("rst");
      RESET_N = 1'b1;
      cyc();
      load_word(16'hA5C3);
      chk("t1_load_word", 32'(WORD_OUT), 32'hA5C3);
      chk("t1_load_rem",  32'(REMAIN),   32'd4);
      chk("t1_load_empty", 32'(EMPTY),   32'd0);
      for (int i = 0; i < 4; i++) begin
         nv0 = nv;
         clean_press();
         chk($sformatf("t1_pop%0d_cnt", i),   32'(nv - nv0),  32'd1);
         chk($sformatf("t1_pop%0d_nib", i),   32'(NIB_OUT),   32'(exp_nib[i]));
         chk($sformatf("t1_pop%0d_word", i),  32'(WORD_OUT),  32'(exp_word[i]));
         chk($sformatf("t1_pop%0d_rem", i),   32'(REMAIN),    32'(3 - i));
         chk($sformatf("t1_pop%0d_empty", i), 32'(EMPTY),     32'(i == 3));
      end

      // 2. latency and long hold
      load_word(16'h0F0D);
      nv0 = nv;
      BTN_N = 1'b0;
      for (int j = 1; j <= 100; j++) begin
         cyc();
         if (j == 6) chk("t2_lat_early", 32'(NIB_VALID), 32'd0);
         if (j == 7) chk("t2_lat_hit",   32'(NIB_VALID), 32'd1);
         if (j == 8) chk("t2_lat_late",  32'(NIB_VALID), 32'd0);
      end
      BTN_N = 1'b1;
      cycles(10);
      chk("t2_hold_cnt", 32'(nv - nv0), 32'd1);
      chk("t2_nib",      32'(NIB_OUT),  32'h0);
      chk("t2_word",     32'(WORD_OUT), 32'hF0D0);
      chk("t2_rem",      32'(REMAIN),   32'd3);

      // 3. bounce rejected, then a clean press
      nv0 = nv;
      ur0 = ur;
      BTN_N = 1'b0; cycles(3);
      BTN_N = 1'b1; cycles(1);
      BTN_N = 1'b0; cycles(3);
      BTN_N = 1'b1; cycles(12);
      chk("t3_bounce_nv",  32'(nv - nv0), 32'd0);
      chk("t3_bounce_ur",  32'(ur - ur0), 32'd0);
      chk("t3_bounce_rem", 32'(REMAIN),   32'd3);
      clean_press();
      chk("t3_pop_cnt", 32'(nv - nv0), 32'd1);
      chk("t3_pop_nib", 32'(NIB_OUT),  32'hF);
      chk("t3_pop_rem", 32'(REMAIN),   32'd2);
      clean_press();
      clean_press();
      chk("t3_drain_nib",   32'(NIB_OUT),  32'hD);
      chk("t3_drain_word",  32'(WORD_OUT), 32'h0000);
      chk("t3_drain_empty", 32'(EMPTY),    32'd1);

      // 4. underrun
      nv0 = nv;
      ur0 = ur;
      clean_press();
      chk("t4_ur_cnt", 32'(ur - ur0), 32'd1);
      chk("t4_nv_cnt", 32'(nv - nv0), 32'd0);
      chk("t4_nib",    32'(NIB_OUT),  32'hD);
      chk("t4_word",   32'(WORD_OUT), 32'h0000);
      chk("t4_rem",    32'(REMAIN),   32'd0);

      // 5. collision of LOAD with a press event, then reload pop
      load_word(16'h1234);
      clean_press();
      chk("t5_first_nib", 32'(NIB_OUT), 32'h1);
      nv0 = nv;
      ur0 = ur;
      BTN_N = 1'b0;
      for (int j = 1; j <= 10; j++) begin
         cyc();
         if (j == 6) begin
            LOAD    = 1'b1;
            DATA_IN = 16'hBEEF;
         end
         if (j == 7) begin
            LOAD = 1'b0;
            chk("t5_coll_valid", 32'(NIB_VALID), 32'd0);
         end
      end
      BTN_N = 1'b1;
      cycles(10);
      chk("t5_coll_nv",   32'(nv - nv0), 32'd0);
      chk("t5_coll_ur",   32'(ur - ur0), 32'd0);
      chk("t5_coll_rem",  32'(REMAIN),   32'd4);
      chk("t5_coll_word", 32'(WORD_OUT), 32'hBEEF);
      chk("t5_coll_nib",  32'(NIB_OUT),  32'h1);
      clean_press();
      chk("t5_next_nib",  32'(NIB_OUT),  32'hB);
      chk("t5_next_word", 32'(WORD_OUT), 32'hEEF0);
      chk("t5_next_rem",  32'(REMAIN),   32'd3);

      // 6. reset mid-operation with the button held
      load_word(16'h1234);
      clean_press();
      clean_press();
      chk("t6_pre_nib",  32'(NIB_OUT),  32'h2);
      chk("t6_pre_word", 32'(WORD_OUT), 32'h3400);
      chk("t6_pre_rem",  32'(REMAIN),   32'd2);
      BTN_N = 1'b0;
      cycles(3);
      RESET_N = 1'b0;
      cyc();
      RESET_N = 1'b1;
      chk_reset_state("t6_rst");
      nv0 = nv;
      ur0 = ur;
      for (int j = 1; j <= 20; j++) begin
         cyc();
         if (j == 6) chk("t6_ur_early", 32'(UNDERRUN), 32'd0);
         if (j == 7) chk("t6_ur_hit",   32'(UNDERRUN), 32'd1);
      end
      BTN_N = 1'b1;
      cycles(10);
      chk("t6_ur_cnt", 32'(ur - ur0), 32'd1);
      chk("t6_nv_cnt", 32'(nv - nv0), 32'd0);
      chk("t6_rem",    32'(REMAIN),   32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
